// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus target side.
package cpu_bus_pkg;

    localparam logic [15:0] PAD1_ADDR = 16'h4016;
    localparam logic [15:0] PAD2_ADDR = 16'h4017;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_PPU,
        REG_PAD1,
        REG_PAD2,
        REG_ROM,
        REG_NONE
    } region_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } rom_state_e;

    // Map a CPU address onto the target that owns it.
    function automatic region_e decode_region(input logic [15:0] a);
        if (a[15])                 return REG_ROM;
        else if (a[15:13] == 3'b000) return REG_RAM;
        else if (a[15:13] == 3'b001) return REG_PPU;
        else if (a == PAD1_ADDR)   return REG_PAD1;
        else if (a == PAD2_ADDR)   return REG_PAD2;
        else                       return REG_NONE;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_ram.sv
// Work RAM: asynchronous read, write committed on the rising edge.
module cpu_bus_responder_ram #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_bus_responder.sv
// CPU bus target: address decode, work RAM, controller ports, open bus,
// PPU window forwarding and wait-stated PRG ROM reads.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW   = 11,
    parameter int unsigned ROM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        write,
    input  logic [7:0]  d_out,
    output logic [7:0]  d_in,
    output logic        ready,
    output logic        ppu_sel,
    output logic        ppu_wr,
    output logic [2:0]  ppu_reg,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic        rom_en,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    input  logic [7:0]  pad1,
    input  logic [7:0]  pad2
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ROM_WAIT);

    region_e          region;
    logic             rom_rd;
    rom_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             strobe_q;
    logic [7:0]       sr1_q, sr2_q;
    logic [7:0]       open_bus_q;
    logic [7:0]       ram_rdata;
    logic             ram_we;
    logic             pad1_bit, pad2_bit;

    assign region    = decode_region(addr);
    assign rom_rd    = (region == REG_ROM) && !write;
    assign ppu_sel   = (region == REG_PPU);
    assign ppu_wr    = ppu_sel && write;
    assign ppu_reg   = addr[2:0];
    assign ppu_wdata = d_out;
    assign rom_addr  = addr[14:0];
    assign ram_we    = ready && write && (region == REG_RAM);

    // While strobing, the port reflects the live button A state.
    assign pad1_bit  = strobe_q ? pad1[7] : sr1_q[7];
    assign pad2_bit  = strobe_q ? pad2[7] : sr2_q[7];

    cpu_bus_responder_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (d_out),
        .rdata (ram_rdata)
    );

    // ROM wait-state FSM: request cycle, then hold until the count expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rom_en  = 1'b0;
        ready   = 1'b1;
        if (ROM_WAIT == 0) begin
            rom_en = rom_rd;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rom_rd) begin
                        rom_en  = 1'b1;
                        ready   = 1'b0;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    ready = (cnt_q == WAIT_LAST);
                    if (cnt_q < WAIT_LAST) cnt_d   = CNT_W'(cnt_q + 1'b1);
                    else                   state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        d_in = open_bus_q;
        case (region)
            REG_RAM:  d_in = ram_rdata;
            REG_PPU:  d_in = ppu_rdata;
            REG_PAD1: d_in = {7'b0100000, pad1_bit};
            REG_PAD2: d_in = {7'b0100000, pad2_bit};
            REG_ROM:  d_in = rom_rdata;
            default:  d_in = open_bus_q;
        endcase
    end

    // Side effects only on completed accesses (ready=1).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            sr1_q      <= 8'hFF;
            sr2_q      <= 8'hFF;
            open_bus_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ready) open_bus_q <= write ? d_out : d_in;
            if (ready && write && (region == REG_PAD1)) strobe_q <= d_out[0];
            if (strobe_q) begin
                sr1_q <= pad1;
                sr2_q <= pad2;
            end else begin
                if (ready && !write && (region == REG_PAD1)) sr1_q <= {sr1_q[6:0], 1'b1};
                if (ready && !write && (region == REG_PAD2)) sr2_q <= {sr2_q[6:0], 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Self-checking bench for cpu_bus_responder with an access-level reference model.
module tb_cpu_bus_responder;

    localparam int unsigned ROM_W = 2;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  d_out;
    logic [7:0]  d_in;
    logic        ready;
    logic        ppu_sel;
    logic        ppu_wr;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;
    logic        rom_en;
    logic [14:0] rom_addr;
    logic [7:0]  rom_rdata;
    logic [7:0]  pad1;
    logic [7:0]  pad2;

    cpu_bus_responder #(.RAM_AW(11), .ROM_WAIT(ROM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .write     (write),
        .d_out     (d_out),
        .d_in      (d_in),
        .ready     (ready),
        .ppu_sel   (ppu_sel),
        .ppu_wr    (ppu_wr),
        .ppu_reg   (ppu_reg),
        .ppu_wdata (ppu_wdata),
        .ppu_rdata (ppu_rdata),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .pad1      (pad1),
        .pad2      (pad2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM image and a slow ROM that only drives valid data ROM_W cycles after the request.
    function automatic logic [7:0] rom_byte(input logic [14:0] a);
        return 8'(a[7:0] * 8'd7 + 8'h4C);
    endfunction

    int          rom_cnt_tb = 0;
    logic [14:0] rom_lat = '0;
    always @(posedge clk) begin
        if (rom_en) begin
            rom_cnt_tb <= ROM_W;
            rom_lat    <= rom_addr;
        end else if (rom_cnt_tb != 0) begin
            rom_cnt_tb <= rom_cnt_tb - 1;
        end
    end
    assign rom_rdata = (rom_cnt_tb == 1) ? rom_byte(rom_lat) : 8'hEE;

    // Reference model state: memory image, controller latch + read count, last bus byte.
    logic [7:0] m_ram [2048];
    logic       m_strobe;
    logic [7:0] m_lat1, m_lat2;
    int         m_cnt1, m_cnt2;
    logic [7:0] m_ob;

    // Expectations consumed by the compare process.
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_rom_en, exp_ppu_sel, exp_ppu_wr, exp_din_valid;
    logic [2:0]  exp_ppu_reg;
    logic [7:0]  exp_wdata, exp_din;
    logic [14:0] exp_rom_addr;
    logic        lit_din_en = 1'b0;
    logic [7:0]  lit_din = 8'h00;
    logic        lit_cnt_en = 1'b0;
    string       lit_cnt_name = "";
    logic [31:0] lit_cnt_act = 0, lit_cnt_exp = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",   32'(ready),   32'(exp_ready));
            chk("rom_en",  32'(rom_en),  32'(exp_rom_en));
            chk("ppu_sel", 32'(ppu_sel), 32'(exp_ppu_sel));
            chk("ppu_wr",  32'(ppu_wr),  32'(exp_ppu_wr));
            if (exp_ppu_sel) begin
                chk("ppu_reg",   32'(ppu_reg),   32'(exp_ppu_reg));
                chk("ppu_wdata", 32'(ppu_wdata), 32'(exp_wdata));
            end
            if (exp_rom_en) chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
            if (exp_ready && exp_din_valid) chk("d_in", 32'(d_in), 32'(exp_din));
            if (exp_ready && lit_din_en) chk("d_in_literal", 32'(d_in), 32'(lit_din));
            if (lit_cnt_en) chk(lit_cnt_name, lit_cnt_act, lit_cnt_exp);
        end
    end

    task automatic model_reset();
        m_strobe = 1'b0;
        m_lat1   = 8'hFF;
        m_lat2   = 8'hFF;
        m_cnt1   = 0;
        m_cnt2   = 0;
        m_ob     = 8'h00;
    endtask

    // Serial port: bit 7 first, then the remaining bits, then all ones.
    function automatic logic pad_bit(input logic [7:0] live, input logic [7:0] lat, input int cnt);
        if (m_strobe)     return live[7];
        else if (cnt < 8) return lat[7 - cnt];
        else              return 1'b1;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a < 16'h2000)       return m_ram[a[10:0]];
        else if (a < 16'h4000)  return ppu_rdata;
        else if (a == 16'h4016) return {7'b0100000, pad_bit(pad1, m_lat1, m_cnt1)};
        else if (a == 16'h4017) return {7'b0100000, pad_bit(pad2, m_lat2, m_cnt2)};
        else if (a >= 16'h8000) return rom_byte(a[14:0]);
        else                    return m_ob;
    endfunction

    task automatic model_commit(input logic [15:0] a, input logic w, input logic [7:0] wd, input logic [7:0] rd);
        if (w && a < 16'h2000) m_ram[a[10:0]] = wd;
        if (m_strobe) begin
            m_lat1 = pad1;
            m_lat2 = pad2;
            m_cnt1 = 0;
            m_cnt2 = 0;
        end else if (!w && a == 16'h4016) begin
            m_cnt1 = (m_cnt1 < 8) ? m_cnt1 + 1 : 8;
        end else if (!w && a == 16'h4017) begin
            m_cnt2 = (m_cnt2 < 8) ? m_cnt2 + 1 : 8;
        end
        if (w && a == 16'h4016) m_strobe = wd[0];
        m_ob = w ? wd : rd;
    endtask

    // One CPU access, held until the DUT reports ready (bounded).
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] wd);
        logic       done;
        logic       rom_read;
        logic [7:0] e;
        addr  = a;
        write = w;
        d_out = wd;
        if (a >= 16'h2000 && a < 16'h4000) ppu_rdata = 8'($urandom);
        rom_read = (a >= 16'h8000) && !w;
        done = 1'b0;
        for (int k = 0; k <= int'(ROM_W) + 3 && !done; k++) begin
            e             = model_read(a);
            exp_ready     = rom_read ? (k == int'(ROM_W)) : 1'b1;
            exp_rom_en    = rom_read && (k == 0);
            exp_ppu_sel   = (a >= 16'h2000) && (a < 16'h4000);
            exp_ppu_wr    = exp_ppu_sel && w;
            exp_ppu_reg   = a[2:0];
            exp_wdata     = wd;
            exp_rom_addr  = a[14:0];
            exp_din       = e;
            exp_din_valid = !w;
            chk_en        = 1'b1;
            @(negedge clk);
            done = ready;
            @(posedge clk);
            lit_cnt_en = 1'b0;
            if (done) model_commit(a, w, wd, e);
            #1;
        end
        lit_din_en = 1'b0;
        if (!done) begin
            lit_cnt_name = "access_timeout";
            lit_cnt_act  = 32'(done);
            lit_cnt_exp  = 32'd1;
            lit_cnt_en   = 1'b1;
        end
    endtask

    function automatic logic [15:0] ram_idx(input int i);
        return (i < 8) ? 16'(i) : 16'(16'h07F8 + 16'(i - 8));
    endfunction

    task automatic lit_read(input logic [15:0] a, input logic [7:0] v);
        lit_din_en = 1'b1;
        lit_din    = v;
        access(a, 1'b0, 8'h00);
    endtask

    int          t0;
    logic [9:0]  seq;
    logic [15:0] ra;
    logic        rw;
    logic [7:0]  rd8;

    initial begin
        reset     = 1'b0;
        addr      = 16'h0000;
        write     = 1'b0;
        d_out     = 8'h00;
        pad1      = 8'h00;
        pad2      = 8'h00;
        ppu_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();

        // Reset state: open bus cleared, pad registers all ones.
        lit_read(16'h5000, 8'h00);
        lit_read(16'h4016, 8'h41);
        lit_read(16'h4017, 8'h41);

        for (int i = 0; i < 16; i++) access(ram_idx(i), 1'b1, 8'($urandom));

        // RAM mirroring.
        access(16'h0005, 1'b1, 8'hA5);
        lit_read(16'h0805, 8'hA5);
        lit_read(16'h1005, 8'hA5);
        lit_read(16'h1805, 8'hA5);

        // ROM wait states and back-to-back timing.
        lit_read(16'h8000, 8'h4C);
        t0 = cyc;
        access(16'h8000, 1'b0, 8'h00);
        access(16'h8001, 1'b0, 8'h00);
        lit_cnt_name = "rom_b2b_cycles";
        lit_cnt_act  = 32'(cyc - t0);
        lit_cnt_exp  = 32'd6;
        lit_cnt_en   = 1'b1;

        // Controller serial read-out.
        pad1 = 8'b1000_0001;
        access(16'h4016, 1'b1, 8'h01);
        access(16'h4016, 1'b1, 8'h00);
        seq = 10'b1000000111;
        for (int i = 0; i < 10; i++) lit_read(16'h4016, 8'h40 | {7'b0, seq[9 - i]});

        // Strobe held: reads track live button A.
        access(16'h4016, 1'b1, 8'h01);
        pad1 = 8'h80;
        lit_read(16'h4016, 8'h41);
        pad1 = 8'h00;
        lit_read(16'h4016, 8'h40);
        pad1 = 8'h80;
        lit_read(16'h4016, 8'h41);
        access(16'h4016, 1'b1, 8'h00);

        // PPU write forwarding and open bus.
        access(16'h2007, 1'b1, 8'h3C);
        lit_read(16'h5000, 8'h3C);

        // Reset while a ROM read is waiting.
        addr          = 16'h8123;
        write         = 1'b0;
        exp_ready     = 1'b0;
        exp_rom_en    = 1'b1;
        exp_ppu_sel   = 1'b0;
        exp_ppu_wr    = 1'b0;
        exp_rom_addr  = 15'h0123;
        exp_din_valid = 1'b0;
        chk_en        = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        reset  = 1'b0;
        addr   = 16'h5000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        lit_read(16'h5000, 8'h00);
        lit_read(16'h4016, 8'h41);
        lit_read(16'h4017, 8'h41);

        // Randomized traffic across every region.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                pad1 = 8'($urandom);
                pad2 = 8'($urandom);
            end
            rw  = 1'($urandom_range(0, 1));
            rd8 = 8'($urandom);
            case ($urandom_range(0, 7))
                0, 1: ra = ram_idx(int'($urandom_range(0, 15))) | 16'(16'($urandom_range(0, 3)) << 11);
                2:    ra = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
                3, 4: begin
                    ra = ($urandom_range(0, 1) == 1) ? 16'h4016 : 16'h4017;
                    rw = ($urandom_range(0, 3) == 0);
                end
                5, 6: ra = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
                default: ra = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
            endcase
            access(ra, rw, rd8);
        end

        access(16'h5000, 1'b0, 8'h00);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target side of the CPU bus: decodes each CPU access (addr/write/d_out), returns read data on d_in and paces slow targets with ready.
- Hosts the 2 KB work RAM, the two controller-port shift registers and the open-bus latch.
- Forwards the PPU register window and the PRG ROM to external ports.
- Sits between the cpu top level and the PPU/cartridge blocks.

Parameters:
- RAM_AW, 11, work RAM address width (2**RAM_AW bytes, mirrored up to $1FFF).
- ROM_WAIT, 1, ready-low cycles per PRG ROM read (1..7); 0 = zero-wait combinational ROM.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  16  CPU address.
- write  in  1  1 = CPU write this cycle.
- d_out  in  8  CPU write data.
- d_in  out  8  read data to CPU.
- ready  out  1  0 = CPU must hold the current access.
- ppu_sel  out  1  access in $2000-$3FFF this cycle.
- ppu_wr  out  1  ppu_sel & write.
- ppu_reg  out  3  addr[2:0].
- ppu_wdata  out  8  = d_out.
- ppu_rdata  in  8  PPU register read data, combinational.
- rom_en  out  1  PRG ROM read request.
- rom_addr  out  15  addr[14:0].
- rom_rdata  in  8  ROM data, valid ROM_WAIT cycles after rom_en.
- pad1, pad2  in  8  controller button states {A,B,Sel,Start,Up,Down,Left,Right}, A = bit 7.

Behaviour:
- Access rule: every cycle with ready=1 is exactly one completed access. Side effects (RAM write, pad shift, open-bus update) happen only on completed accesses.
- Reset (reset=0): rom FSM to IDLE, wait counter 0, strobe 0, both pad shift regs 8'hFF, open_bus 8'h00, ready=1. RAM contents are not cleared.
- Decode:
  - $0000-$1FFF RAM, index addr[RAM_AW-1:0].
  - $2000-$3FFF PPU.
  - $4016 pad1 / strobe.
  - $4017 pad2.
  - $8000-$FFFF ROM.
  - Everything else unmapped.
- RAM:
  - Asynchronous read: d_in = ram[idx] in the same cycle.
  - Write commits at the clock edge ending the cycle.
  - Read of a location in the cycle after writing it returns the new value.
- PPU:
  - ppu_sel combinational.
  - Read: d_in = ppu_rdata in the same cycle.
  - ready stays 1.
- Controller:
  - Write $4016: strobe <= d_out[0]. Writes to $4017 are ignored.
  - While strobe=1: both shift regs reload from pad1/pad2 every cycle.
  - Read $4016: d_in = {7'b0100000, sr1[7]}. If strobe=0, sr1 <= {sr1[6:0],1'b1}.
  - $4017 behaves identically with sr2.
  - After 8 shifts, reads return bit 1.
  - Read while strobe=1 returns the live pad bit 7 and does not shift.
- ROM FSM (ROM_WAIT>0), states IDLE, WAIT:
  - IDLE + ROM read decoded: rom_en=1, ready=0, cnt<=1, go to WAIT.
  - WAIT: rom_en=0, ready = (cnt==ROM_WAIT).
    - cnt<ROM_WAIT: cnt++.
    - cnt==ROM_WAIT: d_in = rom_rdata, access completes, go to IDLE.
  - Back-to-back ROM reads: the new access starts in IDLE the next cycle. Minimum ROM read = ROM_WAIT+1 cycles.
  - ROM writes: ignored, no wait, ready=1.
  - Reset in WAIT: abandons the access, FSM returns to IDLE.
  - ROM_WAIT=0: rom_en combinational on decode, d_in = rom_rdata, ready=1.
- Open bus:
  - open_bus <= d_in on every completed read and <= d_out on every completed write.
  - Unmapped read returns open_bus. Unmapped write is ignored apart from updating open_bus.
- ready is 1 in every case other than the ROM wait described above.

Decomposition:
- Package cpu_bus_pkg:
  - region enum {REG_RAM, REG_PPU, REG_PAD1, REG_PAD2, REG_ROM, REG_NONE}.
  - Address constants PAD1_ADDR=16'h4016, PAD2_ADDR=16'h4017.
  - ROM FSM state enum.
- Sub-module cpu_ram: 2**RAM_AW x 8, async read, sync write enable.
- Decode, FSM, pads and open-bus logic stay in cpu_bus_responder.

Test Plan:
- RAM mirroring: write $0005=8'hA5, then read $0805, $1005, $1805 -> each returns 8'hA5, ready=1 throughout.
- ROM wait (ROM_WAIT=2):
  - Read $8000 with model returning 8'h4C -> rom_en pulses 1 cycle, ready=0 for 2 cycles, then ready=1 with d_in=8'h4C.
  - Back-to-back reads $8000 then $8001 take 6 cycles total.
- Controller: pad1=8'b1000_0001, write $4016=1 then $4016=0, 10 reads of $4016 -> D0 sequence 1,0,0,0,0,0,0,1,1,1; every value has upper bits 8'h40.
- Strobe held: $4016=1 and pad1 toggles bit 7 between reads -> each read follows live pad1[7], no shifting.
- Open bus and PPU: write $2007=8'h3C -> ppu_sel=1, ppu_wr=1, ppu_reg=7, ppu_wdata=8'h3C; next read $5000 -> d_in=8'h3C.
- Reset mid-ROM-wait: assert reset=0 during WAIT -> ready=1 next cycle, FSM in IDLE, open_bus=0, pad shift regs 8'hFF.
